// File: rtl/sys1_input_pkg.sv
// sys1_input_pkg: shared constants and types for the SYS1 input controller.
//   - PS/2 scancodes recognised by the key latches
//   - joystick word and output port bit positions
//   - coin shaper state enum and frame-count limits
//   - helpers that map joystick bits to a control set and a control set to
//     an active-low player port byte
package sys1_input_pkg;

    localparam int unsigned COIN_FRAMES_MAX = 15;
    localparam int unsigned COIN_CNT_W      = 4;

    // PS/2 set-2 scancodes
    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_P1_TRIG1 = 8'h29;
    localparam logic [7:0] SC_P1_TRIG2 = 8'h14;
    localparam logic [7:0] SC_F1       = 8'h05;
    localparam logic [7:0] SC_F2       = 8'h06;
    localparam logic [7:0] SC_START1   = 8'h16;
    localparam logic [7:0] SC_START2   = 8'h1E;
    localparam logic [7:0] SC_COIN1    = 8'h2E;
    localparam logic [7:0] SC_COIN2    = 8'h36;
    localparam logic [7:0] SC_P2_UP    = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT  = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT = 8'h34;
    localparam logic [7:0] SC_P2_TRIG1 = 8'h1C;
    localparam logic [7:0] SC_P2_TRIG2 = 8'h1B;

    // Joystick word bit positions
    localparam int unsigned JOY_R      = 0;
    localparam int unsigned JOY_L      = 1;
    localparam int unsigned JOY_D      = 2;
    localparam int unsigned JOY_U      = 3;
    localparam int unsigned JOY_TRIG1  = 4;
    localparam int unsigned JOY_TRIG2  = 5;
    localparam int unsigned JOY_START1 = 6;
    localparam int unsigned JOY_START2 = 7;
    localparam int unsigned JOY_COIN   = 8;

    // Player port (INP0/INP1) bit positions, active-low
    localparam int unsigned PB_L     = 7;
    localparam int unsigned PB_R     = 6;
    localparam int unsigned PB_U     = 5;
    localparam int unsigned PB_D     = 4;
    localparam int unsigned PB_TRIG2 = 2;
    localparam int unsigned PB_TRIG1 = 1;

    // System port (INP2) bit positions, active-low
    localparam int unsigned SB_START2 = 5;
    localparam int unsigned SB_START1 = 4;
    localparam int unsigned SB_COIN   = 0;

    typedef enum logic [1:0] {
        COIN_IDLE  = 2'd0,
        COIN_PULSE = 2'd1,
        COIN_LOCK  = 2'd2
    } coin_state_e;

    typedef struct packed {
        logic u;
        logic d;
        logic l;
        logic r;
        logic t1;
        logic t2;
    } ctrl_t;

    typedef struct packed {
        ctrl_t p1;
        ctrl_t p2;
        logic  f1;
        logic  f2;
        logic  start1;
        logic  start2;
        logic  coin1;
        logic  coin2;
    } key_latch_t;

    function automatic ctrl_t joy_ctrl(input logic [5:0] j);
        ctrl_t c;
        c.u  = j[JOY_U];
        c.d  = j[JOY_D];
        c.l  = j[JOY_L];
        c.r  = j[JOY_R];
        c.t1 = j[JOY_TRIG1];
        c.t2 = j[JOY_TRIG2];
        return c;
    endfunction

    function automatic logic [7:0] pack_player(input ctrl_t c);
        logic [7:0] p;
        p           = 8'hFF;
        p[PB_L]     = ~c.l;
        p[PB_R]     = ~c.r;
        p[PB_U]     = ~c.u;
        p[PB_D]     = ~c.d;
        p[PB_TRIG2] = ~c.t2;
        p[PB_TRIG1] = ~c.t1;
        return p;
    endfunction

endpackage

// File: rtl/sys1_input_ctrl_if.sv
// sys1_input_ctrl_if: bundles the controller's input sources and port outputs.
//   ps2_key   [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode
//   joystk1/2 joystick words
//   vblank    vertical blank, clk_sys domain
//   cabinet   1 = cocktail, 0 = upright
//   INP0/1/2  active-low player 1, player 2 and system ports
//   coin_busy coin shaper not idle
// master: the source side (drives inputs, reads ports); slave: the controller.
interface sys1_input_ctrl_if;
    logic [10:0] ps2_key;
    logic [15:0] joystk1;
    logic [15:0] joystk2;
    logic        vblank;
    logic        cabinet;
    logic [7:0]  INP0;
    logic [7:0]  INP1;
    logic [7:0]  INP2;
    logic        coin_busy;

    modport master (
        output ps2_key, joystk1, joystk2, vblank, cabinet,
        input  INP0, INP1, INP2, coin_busy
    );

    modport slave (
        input  ps2_key, joystk1, joystk2, vblank, cabinet,
        output INP0, INP1, INP2, coin_busy
    );
endinterface

// File: rtl/sys1_coin_shaper.sv
// sys1_coin_shaper: turns a raw coin level into one fixed-length pulse of
// COIN_FRAMES vblank rising edges, then locks out until the coin is released.
//   clk_sys, rst_n  clock / async active-low reset
//   raw_coin        combined coin request level
//   vblank          vertical blank level
//   coin_pulse      next-cycle pulse level (registered by the caller)
//   busy            state is not IDLE
//
//   state | meaning
//   IDLE  | waiting for a raw coin rising edge
//   PULSE | coin asserted, counting vblank rising edges
//   LOCK  | coin deasserted, waiting for raw coin to go low
module sys1_coin_shaper
    import sys1_input_pkg::*;
#(
    parameter int unsigned COIN_FRAMES = 3
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic raw_coin,
    input  logic vblank,
    output logic coin_pulse,
    output logic busy
);

    localparam int unsigned FRAMES_EFF =
        (COIN_FRAMES > COIN_FRAMES_MAX) ? COIN_FRAMES_MAX :
        (COIN_FRAMES == 0)              ? 1 : COIN_FRAMES;
    localparam logic [COIN_CNT_W-1:0] FRAMES = COIN_CNT_W'(FRAMES_EFF);

    coin_state_e           state, state_nxt;
    logic [COIN_CNT_W-1:0] cnt, cnt_nxt;
    logic                  coin_q;
    logic                  vb_q;
    logic                  coin_rise;
    logic                  vb_rise;

    // coin_q resets to 1 so a coin held through reset is not taken as a
    // new press; it must be seen low first.
    assign coin_rise = raw_coin & ~coin_q;
    assign vb_rise   = vblank & ~vb_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state  <= COIN_IDLE;
            cnt    <= '0;
            coin_q <= 1'b1;
            vb_q   <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            coin_q <= raw_coin;
            vb_q   <= vblank;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            COIN_IDLE: begin
                // a vblank edge in this same cycle is deliberately not counted
                if (coin_rise) begin
                    state_nxt = COIN_PULSE;
                    cnt_nxt   = '0;
                end
            end
            COIN_PULSE: begin
                if (vb_rise) begin
                    if (cnt + COIN_CNT_W'(1) == FRAMES) begin
                        state_nxt = COIN_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + COIN_CNT_W'(1);
                    end
                end
            end
            COIN_LOCK: begin
                if (!raw_coin) begin
                    state_nxt = COIN_IDLE;
                end
            end
            default: begin
                state_nxt = COIN_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Taken from the next state so the caller's port register lines up with
    // the state register.
    assign coin_pulse = (state_nxt == COIN_PULSE);
    assign busy       = (state != COIN_IDLE);

endmodule

// File: rtl/sys1_input_ctrl.sv
// sys1_input_ctrl: merges PS/2 keys and two joysticks into three active-low
// arcade input ports.
//   clk_sys  system clock (48 MHz)
//   rst_n    async active-low reset
//   bus      sys1_input_ctrl_if.slave: ps2_key, joystk1/2, vblank, cabinet in;
//            INP0/INP1/INP2, coin_busy out
// Build option: define SYS1_COIN_SHAPER_EN to shape the coin bit into a
// fixed vblank-counted pulse; otherwise the coin bit is the registered raw
// coin level and coin_busy is tied low.
module sys1_input_ctrl
    import sys1_input_pkg::*;
#(
    parameter int unsigned COIN_FRAMES = 3
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    sys1_input_ctrl_if.slave  bus
);

    logic       toggle_q;
    logic       key_evt;
    logic       pressed;
    key_latch_t keys;
    ctrl_t      p1, p2;
    logic       start1, start2, raw_coin, coin_bit;
    logic [7:0] sys_word;
    logic [7:0] inp0_q, inp1_q, inp2_q;

    assign key_evt = bus.ps2_key[10] ^ toggle_q;
    assign pressed = bus.ps2_key[9];

    // Arrow codes match with or without the extended prefix.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
            keys     <= '0;
        end else begin
            toggle_q <= bus.ps2_key[10];
            if (key_evt) begin
                case (bus.ps2_key[7:0])
                    SC_P1_UP:    keys.p1.u   <= pressed;
                    SC_P1_DOWN:  keys.p1.d   <= pressed;
                    SC_P1_LEFT:  keys.p1.l   <= pressed;
                    SC_P1_RIGHT: keys.p1.r   <= pressed;
                    SC_P1_TRIG1: keys.p1.t1  <= pressed;
                    SC_P1_TRIG2: keys.p1.t2  <= pressed;
                    SC_F1:       keys.f1     <= pressed;
                    SC_F2:       keys.f2     <= pressed;
                    SC_START1:   keys.start1 <= pressed;
                    SC_START2:   keys.start2 <= pressed;
                    SC_COIN1:    keys.coin1  <= pressed;
                    SC_COIN2:    keys.coin2  <= pressed;
                    SC_P2_UP:    keys.p2.u   <= pressed;
                    SC_P2_DOWN:  keys.p2.d   <= pressed;
                    SC_P2_LEFT:  keys.p2.l   <= pressed;
                    SC_P2_RIGHT: keys.p2.r   <= pressed;
                    SC_P2_TRIG1: keys.p2.t1  <= pressed;
                    SC_P2_TRIG2: keys.p2.t2  <= pressed;
                    default: ;
                endcase
            end
        end
    end

    // Opposing directions are passed through as-is.
    always_comb begin
        p2 = keys.p2 | joy_ctrl(bus.joystk2[5:0]);
        p1 = keys.p1 | joy_ctrl(bus.joystk1[5:0]);
        if (!bus.cabinet) begin
            p1 = p1 | p2;
        end
        start1   = keys.f1 | keys.start1 | bus.joystk1[JOY_START1] | bus.joystk2[JOY_START1];
        start2   = keys.f2 | keys.start2 | bus.joystk1[JOY_START2] | bus.joystk2[JOY_START2];
        raw_coin = keys.f1 | keys.f2 | keys.coin1 | keys.coin2
                 | bus.joystk1[JOY_COIN] | bus.joystk2[JOY_COIN];
    end

`ifdef SYS1_COIN_SHAPER_EN
    logic coin_pulse;
    logic shaper_busy;
    logic unused_bits;

    sys1_coin_shaper #(
        .COIN_FRAMES (COIN_FRAMES)
    ) u_coin_shaper (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .raw_coin   (raw_coin),
        .vblank     (bus.vblank),
        .coin_pulse (coin_pulse),
        .busy       (shaper_busy)
    );

    assign coin_bit      = coin_pulse;
    assign bus.coin_busy = shaper_busy;
    assign unused_bits   = ^{bus.ps2_key[8], bus.joystk1[15:9], bus.joystk2[15:9]};
`else
    logic unused_bits;

    assign coin_bit      = raw_coin;
    assign bus.coin_busy = 1'b0;
    assign unused_bits   = ^{bus.ps2_key[8], bus.joystk1[15:9], bus.joystk2[15:9],
                             bus.vblank, COIN_FRAMES[0]};
`endif

    always_comb begin
        sys_word            = 8'hFF;
        sys_word[SB_START2] = ~start2;
        sys_word[SB_START1] = ~start1;
        sys_word[SB_COIN]   = ~coin_bit;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            inp0_q <= 8'hFF;
            inp1_q <= 8'hFF;
            inp2_q <= 8'hFF;
        end else begin
            inp0_q <= pack_player(p1);
            inp1_q <= pack_player(p2);
            inp2_q <= sys_word;
        end
    end

    assign bus.INP0 = inp0_q;
    assign bus.INP1 = inp1_q;
    assign bus.INP2 = inp2_q;

endmodule

// File: tb/tb_sys1_input_ctrl.sv
module tb_sys1_input_ctrl;

    logic clk_sys = 1'b0;
    logic rst_n;
    logic tog = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    sys1_input_ctrl_if bus();

    sys1_input_ctrl #(
        .COIN_FRAMES (3)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic key(input logic prs, input logic ext, input logic [7:0] code);
        tog         = ~tog;
        bus.ps2_key = {tog, prs, ext, code};
    endtask

    task automatic frame();
        bus.vblank = 1'b1;
        tick(3);
        bus.vblank = 1'b0;
        tick(5);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.ps2_key = '0;
        bus.joystk1 = '0;
        bus.joystk2 = '0;
        bus.vblank  = 1'b0;
        bus.cabinet = 1'b1;
        tick(2);
        chk("rst_inp0", bus.INP0, 8'hFF);
        chk("rst_busy", {7'b0, bus.coin_busy}, 8'h00);
        rst_n = 1'b1;
        tick(2);
        chk("idle_inp0", bus.INP0, 8'hFF);
        chk("idle_inp1", bus.INP1, 8'hFF);
        chk("idle_inp2", bus.INP2, 8'hFF);
        chk("idle_busy", {7'b0, bus.coin_busy}, 8'h00);

        // key events: two-cycle latency
        key(1'b1, 1'b1, 8'h75);
        tick(1);
        chk("key_up_lat1", bus.INP0, 8'hFF);
        tick(1);
        chk("key_up_ext", bus.INP0, 8'hDF);
        key(1'b0, 1'b1, 8'h75);
        tick(2);
        chk("key_up_rel", bus.INP0, 8'hFF);
        key(1'b1, 1'b0, 8'h72);
        tick(2);
        chk("key_down_noext", bus.INP0, 8'hEF);
        key(1'b0, 1'b0, 8'h72);
        tick(2);
        chk("key_down_rel", bus.INP0, 8'hFF);
        key(1'b1, 1'b1, 8'h6B);
        tick(1);
        key(1'b1, 1'b1, 8'h74);
        tick(2);
        chk("key_left_right", bus.INP0, 8'h3F);
        key(1'b0, 1'b1, 8'h6B);
        tick(1);
        key(1'b0, 1'b1, 8'h74);
        tick(2);
        chk("key_lr_rel", bus.INP0, 8'hFF);
        // payload change without toggle is not an event
        bus.ps2_key = {tog, 1'b1, 1'b1, 8'h75};
        tick(3);
        chk("key_no_toggle", bus.INP0, 8'hFF);
        key(1'b1, 1'b0, 8'h5A);
        tick(2);
        chk("key_other_inp0", bus.INP0, 8'hFF);
        chk("key_other_inp1", bus.INP1, 8'hFF);
        chk("key_other_inp2", bus.INP2, 8'hFF);
        key(1'b1, 1'b0, 8'h2D);
        tick(2);
        chk("key_p2up_inp1", bus.INP1, 8'hDF);
        chk("key_p2up_inp0_cab1", bus.INP0, 8'hFF);
        bus.cabinet = 1'b0;
        tick(1);
        chk("key_p2up_inp0_cab0", bus.INP0, 8'hDF);
        key(1'b0, 1'b0, 8'h2D);
        bus.cabinet = 1'b1;
        tick(2);
        chk("key_p2up_rel", bus.INP1, 8'hFF);

        // joysticks: one-cycle latency
        bus.cabinet = 1'b0;
        bus.joystk2 = 16'h0010;
        tick(1);
        chk("joy2_t1_cab0_inp0", bus.INP0, 8'hFD);
        chk("joy2_t1_cab0_inp1", bus.INP1, 8'hFD);
        bus.cabinet = 1'b1;
        tick(1);
        chk("joy2_t1_cab1_inp0", bus.INP0, 8'hFF);
        chk("joy2_t1_cab1_inp1", bus.INP1, 8'hFD);
        bus.joystk2 = '0;
        bus.joystk1 = 16'h000C;
        tick(1);
        chk("joy1_ud", bus.INP0, 8'hCF);
        bus.joystk1 = 16'h0003;
        tick(1);
        chk("joy1_lr", bus.INP0, 8'h3F);
        bus.joystk1 = 16'h0020;
        tick(1);
        chk("joy1_t2", bus.INP0, 8'hFB);
        bus.joystk1 = 16'h0040;
        tick(1);
        chk("joy1_start1", bus.INP2, 8'hEF);
        bus.joystk1 = '0;
        bus.joystk2 = 16'h0080;
        tick(1);
        chk("joy2_start2", bus.INP2, 8'hDF);
        bus.joystk2 = '0;
        tick(1);
        chk("joy_clear", bus.INP2, 8'hFF);

`ifdef SYS1_COIN_SHAPER_EN
        // held coin: one 3-frame pulse, then locked
        bus.joystk1 = 16'h0100;
        tick(1);
        chk("coin_start", bus.INP2, 8'hFE);
        chk("coin_start_busy", {7'b0, bus.coin_busy}, 8'h01);
        for (int i = 1; i <= 10; i++) begin
            frame();
            chk($sformatf("coin_hold_f%0d", i), {7'b0, bus.INP2[0]}, (i < 3) ? 8'h00 : 8'h01);
            chk($sformatf("coin_hold_busy_f%0d", i), {7'b0, bus.coin_busy}, 8'h01);
        end
        bus.joystk1 = '0;
        tick(1);
        chk("coin_release_busy", {7'b0, bus.coin_busy}, 8'h00);
        chk("coin_release_inp2", bus.INP2, 8'hFF);
        // re-press, release and re-press inside the pulse
        bus.joystk1 = 16'h0100;
        tick(1);
        chk("coin_repress", bus.INP2, 8'hFE);
        frame();
        chk("coin_bounce_f1", {7'b0, bus.INP2[0]}, 8'h00);
        bus.joystk1 = '0;
        tick(1);
        chk("coin_bounce_rel", {7'b0, bus.INP2[0]}, 8'h00);
        bus.joystk1 = 16'h0100;
        tick(1);
        frame();
        chk("coin_bounce_f2", {7'b0, bus.INP2[0]}, 8'h00);
        frame();
        chk("coin_bounce_f3", {7'b0, bus.INP2[0]}, 8'h01);
        chk("coin_bounce_lock", {7'b0, bus.coin_busy}, 8'h01);
        bus.joystk1 = '0;
        tick(1);
        chk("coin_bounce_idle", {7'b0, bus.coin_busy}, 8'h00);
        frame();
        frame();
        chk("coin_no_queue", bus.INP2, 8'hFF);
        chk("coin_no_queue_busy", {7'b0, bus.coin_busy}, 8'h00);
        // vblank edge coincident with coin edge is not counted
        bus.vblank  = 1'b1;
        bus.joystk1 = 16'h0100;
        tick(3);
        bus.vblank = 1'b0;
        tick(5);
        chk("coin_coinc_f0", {7'b0, bus.INP2[0]}, 8'h00);
        frame();
        frame();
        chk("coin_coinc_f2", {7'b0, bus.INP2[0]}, 8'h00);
        frame();
        chk("coin_coinc_f3", {7'b0, bus.INP2[0]}, 8'h01);
        bus.joystk1 = '0;
        tick(1);
        chk("coin_coinc_idle", {7'b0, bus.coin_busy}, 8'h00);
`else
        bus.joystk1 = 16'h0100;
        tick(1);
        chk("coin_raw_on", bus.INP2, 8'hFE);
        bus.joystk1 = '0;
        tick(1);
        chk("coin_raw_off", bus.INP2, 8'hFF);
        key(1'b1, 1'b0, 8'h05);
        tick(1);
        chk("key_f1_lat1", bus.INP2, 8'hFF);
        tick(1);
        chk("key_f1", bus.INP2, 8'hEE);
        key(1'b0, 1'b0, 8'h05);
        tick(2);
        chk("key_f1_rel", bus.INP2, 8'hFF);
`endif

        // asynchronous reset during an active coin
        bus.joystk1 = 16'h0100;
        tick(1);
        chk("coin_pre_rst", bus.INP2, 8'hFE);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_inp2", bus.INP2, 8'hFF);
        chk("rst_async_busy", {7'b0, bus.coin_busy}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(3);
`ifdef SYS1_COIN_SHAPER_EN
        chk("rst_held_no_pulse", bus.INP2, 8'hFF);
        chk("rst_held_busy", {7'b0, bus.coin_busy}, 8'h00);
`else
        chk("rst_held_raw", bus.INP2, 8'hFE);
`endif
        bus.joystk1 = '0;
        tick(1);
        chk("rst_rel", bus.INP2, 8'hFF);
        bus.joystk1 = 16'h0100;
        tick(1);
        chk("rst_repress", bus.INP2, 8'hFE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
